hidden_bias_relu: RTL and testbench

- Downstream neighbour of the first-layer weighted-sum accumulator.
- On each accumulator completion pulse (add_bias), captures the neuron's weighted sum, adds the neuron bias, applies ReLU, rescales and saturates, and writes the result into an NHIDDEN-entry hidden-activation buffer.
- Requests the next neuron from the upstream sequencer, flags layer completion, and offers a registered read port to the second layer.

---
 rtl/mnist_pkg.sv | 31 +++
 rtl/relu_scale_sat.sv | 24 ++
 rtl/hidden_bias_relu.sv | 104 ++++++++++
 tb/tb_hidden_bias_relu.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mnist_pkg.sv
// Shared constants and types for the MNIST inference datapath.
// Widths here are used by both hidden and output layers.
package mnist_pkg;

  localparam int NWBITS     = 16;
  localparam int COUNT_BIT1 = 10;
  localparam int NHIDDEN    = 32;
  localparam int HBITS      = 5;
  localparam int FRAC_SHIFT = 8;
  localparam int NOUTBITS   = 16;

  localparam int WSBITS  = NWBITS + COUNT_BIT1;
  localparam int SUMBITS = WSBITS + 1;
  localparam int ACT_MAX = 2**(NOUTBITS-1) - 1;

  typedef logic signed [WSBITS-1:0]  wsum_t;
  typedef logic signed [SUMBITS-1:0] sum_t;
  typedef logic [NOUTBITS-1:0]       act_t;

  typedef enum logic {
    COLLECT,
    DONE
  } layer_state_t;

  typedef struct packed {
    logic             valid;
    logic [HBITS-1:0] idx;
    sum_t             sum;
  } bias_s1_t;

endpackage

// File: rtl/relu_scale_sat.sv
// Combinational ReLU, fixed-point rescale and saturation.
// Shared by both network layers.
module relu_scale_sat
  import mnist_pkg::*;
#(
  parameter int SW = SUMBITS
) (
  input  logic signed [SW-1:0] sum,
  output logic [NOUTBITS-1:0]  act
);

  localparam logic [SW-1:0] MAXV = SW'(ACT_MAX);

  logic [SW-1:0] relu;
  logic [SW-1:0] scaled;

  always_comb begin
    relu   = sum[SW-1] ? '0 : sum;
    scaled = relu >> FRAC_SHIFT;
    act    = (scaled > MAXV) ? NOUTBITS'(ACT_MAX)
                             : scaled[NOUTBITS-1:0];
  end

endmodule

// File: rtl/hidden_bias_relu.sv
// Hidden-layer bias add, activation and activation buffer.
// Two-cycle pipeline from add_bias to buffer write.
module hidden_bias_relu
  import mnist_pkg::*;
(
  input  logic                              clk,
  input  logic                              reset_b,
  input  logic                              add_bias,
  input  logic signed [NWBITS+COUNT_BIT1-1:0] weighted_sum,
  input  logic signed [NWBITS-1:0]          bias_in,
  output logic [HBITS-1:0]                  bias_addr,
  input  logic                              clear_layer,
  output logic                              next_neuron,
  output logic                              layer_done,
  output logic                              seq_err,
  input  logic [HBITS-1:0]                  hidden_rd_addr,
  output logic [NOUTBITS-1:0]               hidden_rd_data
);

  localparam logic [HBITS:0]   N_HID = (HBITS+1)'(NHIDDEN);
  localparam logic [HBITS-1:0] LAST  = HBITS'(NHIDDEN-1);

  layer_state_t   state_q;
  layer_state_t   state_d;
  logic [HBITS:0] accept_idx;
  logic           prev_acc;
  logic           accept;
  logic           wr_en;
  bias_s1_t       s1_q;
  act_t           act;
  act_t           buffer [NHIDDEN];

  relu_scale_sat u_rss (
    .sum (s1_q.sum),
    .act (act)
  );

  assign bias_addr  = accept_idx[HBITS-1:0];
  assign layer_done = (state_q == DONE);
  assign wr_en      = s1_q.valid && !clear_layer;

  // Back-to-back pulses would outrun the bias ROM read.
  assign accept = add_bias && !clear_layer
               && (state_q == COLLECT)
               && (accept_idx < N_HID)
               && !prev_acc;

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      clear_layer:
        state_d = COLLECT;
      wr_en && (s1_q.idx == LAST):
        state_d = DONE;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_b) state_q <= COLLECT;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      accept_idx     <= '0;
      prev_acc       <= 1'b0;
      s1_q           <= '0;
      next_neuron    <= 1'b0;
      seq_err        <= 1'b0;
      hidden_rd_data <= '0;
      for (int i = 0; i < NHIDDEN; i++)
        buffer[i] <= '0;
    end else begin
      prev_acc   <= accept;
      s1_q.valid <= accept;
      if (accept) begin
        s1_q.idx <= accept_idx[HBITS-1:0];
        s1_q.sum <= sum_t'(weighted_sum)
                  + sum_t'(bias_in);
      end

      if (clear_layer)
        accept_idx <= '0;
      else if (accept)
        accept_idx <= accept_idx + 1'b1;

      next_neuron <= wr_en && (s1_q.idx != LAST);

      if (clear_layer)
        seq_err <= 1'b0;
      else if (add_bias && !accept)
        seq_err <= 1'b1;

      if (wr_en)
        buffer[s1_q.idx] <= act;

      hidden_rd_data <=
        ({1'b0, hidden_rd_addr} < N_HID)
          ? buffer[hidden_rd_addr] : '0;
    end
  end

endmodule

// File: tb/tb_hidden_bias_relu.sv
// Randomized bench for hidden_bias_relu against an
// event-scheduled reference model of the layer.
module tb_hidden_bias_relu;
  import mnist_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset_b;
  logic                  add_bias;
  logic signed [25:0]    weighted_sum;
  logic signed [15:0]    bias_in;
  logic [4:0]            bias_addr;
  logic                  clear_layer;
  logic                  next_neuron;
  logic                  layer_done;
  logic                  seq_err;
  logic [4:0]            hidden_rd_addr;
  logic [15:0]           hidden_rd_data;

  always #5 clk = ~clk;

  hidden_bias_relu dut (
    .clk            (clk),
    .reset_b        (reset_b),
    .add_bias       (add_bias),
    .weighted_sum   (weighted_sum),
    .bias_in        (bias_in),
    .bias_addr      (bias_addr),
    .clear_layer    (clear_layer),
    .next_neuron    (next_neuron),
    .layer_done     (layer_done),
    .seq_err        (seq_err),
    .hidden_rd_addr (hidden_rd_addr),
    .hidden_rd_data (hidden_rd_data)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, longint got,
                       longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d",
               tag, got, exp);
    end
  endtask

  // Reference model: writes are scheduled events that
  // land one edge after the accepting edge.
  typedef struct {
    int     due;
    int     idx;
    longint val;
  } wr_t;

  longint mbuf [32];
  wr_t    pend [$];
  int     mcnt;
  bit     mdone, merr, mprev, mnn;
  longint exp_rd;
  int     cyc;
  int     nn_cnt;
  logic   rstn = 1'b1;

  function automatic longint act_ref(longint s);
    longint r;
    if (s < 0) return 0;
    r = s / (longint'(1) << FRAC_SHIFT);
    return (r > ACT_MAX) ? ACT_MAX : r;
  endfunction

  task automatic model(bit ab, longint ws, longint b,
                       bit clr, int ra);
    bit  acc;
    wr_t w;
    if (!rstn) begin
      foreach (mbuf[i]) mbuf[i] = 0;
      pend.delete();
      mcnt = 0; mdone = 0; merr = 0;
      mprev = 0; mnn = 0; exp_rd = 0;
    end else begin
      exp_rd = mbuf[ra];
      acc = ab && !clr && !mdone
         && mcnt < 32 && !mprev;
      mnn = 0;
      if (clr) begin
        pend.delete();
        mcnt = 0;
        mdone = 0;
      end else if (pend.size() > 0
                   && pend[0].due == cyc) begin
        w = pend.pop_front();
        mbuf[w.idx] = w.val;
        mnn = (w.idx < 31);
        if (w.idx == 31) mdone = 1;
      end
      if (clr) merr = 0;
      else if (ab && !acc) merr = 1;
      if (acc) begin
        w.due = cyc + 1;
        w.idx = mcnt;
        w.val = act_ref(ws + b);
        pend.push_back(w);
        mcnt++;
      end
      mprev = acc;
    end
    cyc++;
  endtask

  task automatic step(bit ab, longint ws, longint b,
                      bit clr, int ra);
    reset_b        = rstn;
    add_bias       = ab;
    weighted_sum   = ws[25:0];
    bias_in        = b[15:0];
    clear_layer    = clr;
    hidden_rd_addr = ra[4:0];
    @(posedge clk);
    model(ab, ws, b, clr, ra);
    #1;
    if (next_neuron === 1'b1) nn_cnt++;
    check("next_neuron", next_neuron, mnn);
    check("layer_done", layer_done, mdone);
    check("seq_err", seq_err, merr);
    check("bias_addr", bias_addr, mcnt % 32);
    check("rd_data", hidden_rd_data, exp_rd);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, $urandom_range(0, 31));
  endtask

  task automatic rd(int a, longint exp, string tag);
    step(0, 0, 0, 0, a);
    check(tag, hidden_rd_data, exp);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    step(0, 0, 0, 0, 0);
    rstn = 1'b1;
  endtask

  initial begin
    cyc = 0;
    nn_cnt = 0;
    do_reset();
    do_reset();
    check("rst_done", layer_done, 0);
    check("rst_addr", bias_addr, 0);

    // basic
    step(1, 1000, 24, 0, 0);
    step(0, 0, 0, 0, 0);
    check("basic_nn", next_neuron, 1);
    rd(0, 4, "basic_rd");

    // relu and saturation
    step(0, 0, 0, 1, 0);
    step(1, -500, 100, 0, 0);
    idle(3);
    step(1, 33554431, 32767, 0, 0);
    idle(3);
    step(1, 255, 0, 0, 0);
    idle(3);
    rd(0, 0, "relu_neg");
    rd(1, 32767, "relu_sat");
    rd(2, 0, "relu_small");

    // consecutive pulses
    step(0, 0, 0, 1, 0);
    step(1, 512, 0, 0, 0);
    step(1, 768, 0, 0, 0);
    check("spacing_err", seq_err, 1);
    check("spacing_idx", bias_addr, 1);
    idle(3);

    // clear squashes in-flight write
    step(0, 0, 0, 1, 0);
    step(1, 5000, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0);
    check("clr_nn", next_neuron, 0);
    check("clr_addr", bias_addr, 0);
    step(1, 9000, 0, 1, 0);
    check("clr_ab_addr", bias_addr, 0);
    idle(3);

    // full layer
    step(0, 0, 0, 1, 0);
    nn_cnt = 0;
    for (int k = 0; k < 32; k++) begin
      step(1, 256 * k, 0, 0, $urandom_range(0, 31));
      if (k == 31) begin
        check("done_early", layer_done, 0);
        step(0, 0, 0, 0, 0);
        check("done_rise", layer_done, 1);
        idle(782);
      end else begin
        idle(783);
      end
    end
    check("nn_count", nn_cnt, 31);
    check("done_hold", layer_done, 1);
    step(1, 1 << 20, 0, 0, 0);
    idle(3);
    check("ovf_err", seq_err, 1);
    for (int k = 0; k < 32; k++)
      rd(k, k, "layer_rd");
    step(0, 0, 0, 1, 0);
    check("clr_done", layer_done, 0);
    for (int k = 0; k < 32; k++)
      rd(k, k, "retain_rd");

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit     ab, clr;
      longint ws, b;
      ab  = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 60) == 0);
      ws  = longint'($urandom_range(0, 4000000))
          - 2000000;
      if ($urandom_range(0, 9) == 0)
        ws = longint'($urandom_range(0, 33554431));
      b   = longint'($urandom_range(0, 65535)) - 32768;
      if ($urandom_range(0, 500) == 0) do_reset();
      step(ab, ws, b, clr, $urandom_range(0, 31));
    end

    // reset mid-layer
    step(0, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      step(1, 256 * (k + 3), 0, 0, 0);
      idle(2);
    end
    do_reset();
    check("mid_nn", next_neuron, 0);
    check("mid_err", seq_err, 0);
    for (int k = 0; k < 32; k++)
      rd(k, 0, "mid_rd");
    step(1, 256 * 7, 0, 0, 0);
    idle(2);
    rd(0, 7, "mid_first");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
